rv32_bus_arbiter: RTL and testbench
===================================

# rv32_bus_arbiter

Shares the single external memory bus between the core's instruction-fetch port and data (memory-stage) port. It sits between the fetch/mem stages and the bus, and returns per-port ready strobes that feed the hazard unit's `instr_ready_in` / `data_ready_in`. Arbitration is round-robin on contention, and the grant is locked for the whole of a transaction until the bus signals ready.

## Interface
Parameters:
- None; address and data are fixed at 32 bits and the write mask at 4 bits.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `instr_address_in`  in  32  fetch address.
- `instr_read_in`  in  1  fetch read request.
- `instr_read_value_out`  out  32  fetch read data.
- `instr_ready_out`  out  1  fetch transaction complete.
- `data_address_in`  in  32  data address.
- `data_read_in`  in  1  data read request.
- `data_write_in`  in  1  data write request; never asserted together with `data_read_in`.
- `data_write_mask_in`  in  4  byte enables.
- `data_write_value_in`  in  32  write data.
- `data_read_value_out`  out  32  data read data.
- `data_ready_out`  out  1  data transaction complete.
- `bus_address_out`  out  32  shared bus address.
- `bus_read_out`  out  1  shared bus read strobe.
- `bus_write_out`  out  1  shared bus write strobe.
- `bus_write_mask_out`  out  4  shared bus byte enables.
- `bus_write_value_out`  out  32  shared bus write data.
- `bus_read_value_in`  in  32  shared bus read data.
- `bus_ready_in`  in  1  shared bus transaction complete.

## Operation
Request terms:
- `instr_req` = `instr_read_in`.
- `data_req` = `data_read_in | data_write_in`.

Registered state:
- `state`: IDLE or BUSY.
- `owner`: INSTR or DATA, valid in BUSY.
- `last`: INSTR or DATA, the most recently completed port.

Current port `sel`:
- In BUSY, `sel` = `owner`.
- In IDLE, if only one port requests, `sel` is that port.
- In IDLE, if both request, `sel` is the port that is not `last`.
- In IDLE with no request, `sel` is don't-care and all bus strobes are 0.

Bus drive (combinational):
- `bus_*_out` carry the fields of `sel`.
- For the INSTR port: `bus_write_out` = 0, mask = 0, write value = 0.
- With no active request, address, mask and value are driven 0.

Ready and read data:
- `instr_ready_out` = `bus_ready_in` & active & `sel`==INSTR & `instr_req`. `data_ready_out` is formed the same way for DATA.
- `bus_read_value_in` fans out to both `*_read_value_out` unconditionally.

Transitions:
- IDLE, request active, `!bus_ready_in`: go to BUSY, `owner` <= `sel`.
- IDLE, request active, `bus_ready_in`: zero-wait completion; stay IDLE, `last` <= `sel`.
- BUSY, `!bus_ready_in`: hold. `owner`'s strobes stay asserted, using its live inputs.
- BUSY, `bus_ready_in`: go to IDLE, `last` <= `owner`.

Flush mid-transaction (owner drops its request while BUSY):
- The bus cycle cannot be aborted. The arbiter keeps asserting the locked strobe type using registered copies of address, mask and value until `bus_ready_in`.
- The matching `*_ready_out` stays 0, so the dropped transaction is completed silently.
- The registered copies load on every IDLE-to-BUSY transition.

Non-owner requests wait. Their ready stays 0 until they are granted.

Reset (async, `reset_n`=0): `state`=IDLE, `last`=INSTR, registered copies = 0. Bus strobes and readies follow combinationally from the requests.

## Timing
- Arbitration adds no cycle: a request seen in IDLE reaches the bus in the same cycle.
- Transaction latency equals bus latency. `*_ready_out` is combinational from `bus_ready_in`.
- Worst-case wait for a requester: one full transaction of the other port.
- The grant never changes while in BUSY.
- Reset asserted mid-BUSY drops to IDLE immediately. The bus strobe then follows the live requests.

## Test plan
- Fetch only, address 0x100, bus ready after 2 cycles: `bus_read_out`=1 and `bus_address_out`=0x100 for 3 cycles; `instr_ready_out` pulses in the 3rd cycle with read value 0xDEADBEEF.
- Both request from reset (fetch 0x200, data write 0x8000, mask 0xF, value 0x12345678), bus ready after 1 wait cycle each: data is served first (`last`=INSTR), then the fetch; no overlap, and each ready pulses exactly once.
- Continuous contention with zero-wait bus: grants alternate DATA, INSTR, DATA, INSTR on consecutive cycles.
- Fetch granted (address 0x40), `instr_read_in` dropped after 1 cycle, bus ready 3 cycles later: the bus keeps reading 0x40 until ready, `instr_ready_out` stays 0, and a pending data request is granted the cycle after.
- Data read in BUSY with `reset_n` pulsed low mid-transaction: outputs revert immediately with `state`=IDLE; after release, with both requesting, data wins.
- Write strobe isolation: a fetch granted while `data_write_in`=1 is pending gives `bus_write_out`=0 and `bus_write_mask_out`=0 throughout the fetch.

Source files
------------

// File: rtl/rv32_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between the fetch port and the data port.
// A grant stays locked until the bus reports ready, and a dropped request is completed silently.
module rv32_bus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic {P_INSTR, P_DATA} port_t;

  state_t      r_state;
  port_t       r_owner;
  port_t       r_last;
  logic [31:0] r_addr;
  logic [31:0] r_wval;
  logic [3:0]  r_mask;
  logic        r_write;

  logic  w_instr_req;
  logic  w_data_req;
  logic  w_active;
  logic  w_owner_live;
  port_t w_sel;

  // A contended idle cycle goes to whichever port did not complete most recently.
  always_comb begin
    w_instr_req  = instr_read_in;
    w_data_req   = data_read_in | data_write_in;
    w_active     = (r_state == S_BUSY) || w_instr_req || w_data_req;
    w_owner_live = (r_owner == P_INSTR) ? w_instr_req : w_data_req;
    w_sel        = P_INSTR;
    if (r_state == S_BUSY) begin
      w_sel = r_owner;
    end else if (w_instr_req && w_data_req) begin
      if (r_last == P_INSTR) w_sel = P_DATA;
      else                   w_sel = P_INSTR;
    end else if (w_data_req) begin
      w_sel = P_DATA;
    end
  end

  always_comb begin
    bus_read_out        = 1'b0;
    bus_write_out       = 1'b0;
    bus_address_out     = '0;
    bus_write_mask_out  = '0;
    bus_write_value_out = '0;
    if (r_state == S_BUSY && !w_owner_live) begin
      // The owner was flushed; the bus cycle finishes on the captured copy.
      bus_read_out        = ~r_write;
      bus_write_out       = r_write;
      bus_address_out     = r_addr;
      bus_write_mask_out  = r_mask;
      bus_write_value_out = r_wval;
    end else if (w_active) begin
      if (w_sel == P_INSTR) begin
        bus_read_out    = instr_read_in;
        bus_address_out = instr_address_in;
      end else begin
        bus_read_out        = data_read_in;
        bus_write_out       = data_write_in;
        bus_address_out     = data_address_in;
        bus_write_mask_out  = data_write_mask_in;
        bus_write_value_out = data_write_value_in;
      end
    end
  end

  always_comb begin
    instr_ready_out      = bus_ready_in & w_active & (w_sel == P_INSTR) & w_instr_req;
    data_ready_out       = bus_ready_in & w_active & (w_sel == P_DATA) & w_data_req;
    instr_read_value_out = bus_read_value_in;
    data_read_value_out  = bus_read_value_in;
  end

  // In idle the bus already carries the selected port's fields, so those are what get captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= P_INSTR;
      r_last  <= P_INSTR;
      r_addr  <= '0;
      r_wval  <= '0;
      r_mask  <= '0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_instr_req || w_data_req) begin
            if (bus_ready_in) begin
              r_last <= w_sel;
            end else begin
              r_state <= S_BUSY;
              r_owner <= w_sel;
              r_addr  <= bus_address_out;
              r_wval  <= bus_write_value_out;
              r_mask  <= bus_write_mask_out;
              r_write <= bus_write_out;
            end
          end
        end
        S_BUSY: begin
          if (bus_ready_in) begin
            r_state <= S_IDLE;
            r_last  <= r_owner;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter: per-cycle vector table plus hand-written reset sequences.
module tb_rv32_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;

  int errors = 0;
  int checks = 0;

  rv32_bus_arbiter dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .bus_address_out      (bus_address_out),
    .bus_read_out         (bus_read_out),
    .bus_write_out        (bus_write_out),
    .bus_write_mask_out   (bus_write_mask_out),
    .bus_write_value_out  (bus_write_value_out),
    .bus_read_value_in    (bus_read_value_in),
    .bus_ready_in         (bus_ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [3:0]  dm;
    logic [31:0] da;
    logic [31:0] dv;
    logic        br;
    logic [31:0] rv;
    logic        eRead;
    logic        eWrite;
    logic [31:0] eAddr;
    logic [3:0]  eMask;
    logic [31:0] eWval;
    logic        eIready;
    logic        eDready;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [135:0] outWord();
    return {bus_read_out, bus_write_out, bus_address_out, bus_write_mask_out,
            bus_write_value_out, instr_ready_out, data_ready_out,
            instr_read_value_out, data_read_value_out};
  endfunction

  function automatic logic [135:0] expWord(input logic r, input logic w, input logic [31:0] a,
                                           input logic [3:0] m, input logic [31:0] v,
                                           input logic ir, input logic dr, input logic [31:0] rv);
    return {r, w, a, m, v, ir, dr, rv, rv};
  endfunction

  task automatic applyStimulus(input vec_t t);
    instr_read_in       = t.ir;
    instr_address_in    = t.ia;
    data_read_in        = t.dr;
    data_write_in       = t.dw;
    data_write_mask_in  = t.dm;
    data_address_in     = t.da;
    data_write_value_in = t.dv;
    bus_ready_in        = t.br;
    bus_read_value_in   = t.rv;
  endtask

  task automatic checkOutput(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t idleVec;
    // Fetch 0x100, bus ready on the third cycle.
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b0};
    // Both request after a fetch completed: data write wins, then fetch 0x200.
    vecs[3]  = '{1'b1, 32'h200, 1'b0, 1'b1, 4'hF, 32'h8000, 32'h12345678, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h8000, 4'hF, 32'h12345678, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h200, 1'b0, 1'b1, 4'hF, 32'h8000, 32'h12345678, 1'b1, 32'h11111111,
                 1'b0, 1'b1, 32'h8000, 4'hF, 32'h12345678, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h22222222,
                 1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 1'b1, 1'b0};
    // Zero-wait contention alternates DATA, INSTR, DATA, INSTR.
    vecs[7]  = '{1'b1, 32'h300, 1'b1, 1'b0, 4'h0, 32'h900, 32'h0, 1'b1, 32'h33333333,
                 1'b1, 1'b0, 32'h900, 4'h0, 32'h0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'h300, 1'b1, 1'b0, 4'h0, 32'h900, 32'h0, 1'b1, 32'h44444444,
                 1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h300, 1'b1, 1'b0, 4'h0, 32'h900, 32'h0, 1'b1, 32'h55555555,
                 1'b1, 1'b0, 32'h900, 4'h0, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'h300, 1'b1, 1'b0, 4'h0, 32'h900, 32'h0, 1'b1, 32'h66666666,
                 1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 1'b1, 1'b0};
    // Fetch 0x40 flushed after one cycle; the captured address stays on the bus.
    vecs[11] = '{1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'hFF0, 1'b1, 1'b0, 4'h0, 32'hA00, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[13] = vecs[12];
    vecs[14] = '{1'b0, 32'hFF0, 1'b1, 1'b0, 4'h0, 32'hA00, 32'h0, 1'b1, 32'h77777777,
                 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'hA00, 32'h0, 1'b1, 32'h88888888,
                 1'b1, 1'b0, 32'hA00, 4'h0, 32'h0, 1'b0, 1'b1};
    // Fetch granted over a pending write: no write strobe or mask leaks onto the bus.
    vecs[16] = '{1'b1, 32'h500, 1'b0, 1'b1, 4'h3, 32'hB00, 32'hCAFE0000, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h500, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[17] = vecs[16];
    vecs[18] = '{1'b1, 32'h500, 1'b0, 1'b1, 4'h3, 32'hB00, 32'hCAFE0000, 1'b1, 32'h99999999,
                 1'b1, 1'b0, 32'h500, 4'h0, 32'h0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'h3, 32'hB00, 32'hCAFE0000, 1'b1, 32'h0,
                 1'b0, 1'b1, 32'hB00, 4'h3, 32'hCAFE0000, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hABCD0123,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};

    idleVec = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};

    reset_n = 1'b0;
    applyStimulus(idleVec);
    #2;
    checkOutput("reset_idle", outWord(), expWord(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    instr_read_in    = 1'b1;
    instr_address_in = 32'h700;
    #1;
    checkOutput("reset_live_fetch", outWord(), expWord(1'b1, 1'b0, 32'h700, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    applyStimulus(idleVec);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), outWord(),
                  expWord(vecs[i].eRead, vecs[i].eWrite, vecs[i].eAddr, vecs[i].eMask,
                          vecs[i].eWval, vecs[i].eIready, vecs[i].eDready, vecs[i].rv));
    end

    // Data read locked in BUSY, then flushed, then reset mid-transaction.
    @(posedge clk);
    #1;
    applyStimulus(idleVec);
    data_read_in    = 1'b1;
    data_address_in = 32'hC00;
    @(negedge clk);
    checkOutput("rst_seq_grant", outWord(), expWord(1'b1, 1'b0, 32'hC00, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    data_read_in    = 1'b0;
    data_address_in = 32'h0;
    @(negedge clk);
    checkOutput("rst_seq_flushed", outWord(), expWord(1'b1, 1'b0, 32'hC00, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_seq_revert", outWord(), expWord(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    instr_read_in     = 1'b1;
    instr_address_in  = 32'h600;
    data_read_in      = 1'b1;
    data_address_in   = 32'hD00;
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h0BADF00D;
    @(negedge clk);
    checkOutput("rst_seq_data_wins", outWord(),
                expWord(1'b1, 1'b0, 32'hD00, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
